// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register word offsets
// (byte offset >> 2, matching paddr[6:2]) and the register count.
package gpio_pkg;

    localparam int GPIO_NUM_REGS = 16;

    localparam logic [4:0] GPIO_OFS_DR       = 5'h00;
    localparam logic [4:0] GPIO_OFS_DDR      = 5'h01;
    localparam logic [4:0] GPIO_OFS_SET      = 5'h02;
    localparam logic [4:0] GPIO_OFS_CLR      = 5'h03;
    localparam logic [4:0] GPIO_OFS_TGL      = 5'h04;
    localparam logic [4:0] GPIO_OFS_EXT      = 5'h05;
    localparam logic [4:0] GPIO_OFS_INTEN    = 5'h06;
    localparam logic [4:0] GPIO_OFS_INTMASK  = 5'h07;
    localparam logic [4:0] GPIO_OFS_INTTYPE  = 5'h08;
    localparam logic [4:0] GPIO_OFS_POLARITY = 5'h09;
    localparam logic [4:0] GPIO_OFS_BOTHEDGE = 5'h0A;
    localparam logic [4:0] GPIO_OFS_RAWSTAT  = 5'h0B;
    localparam logic [4:0] GPIO_OFS_INTSTAT  = 5'h0C;
    localparam logic [4:0] GPIO_OFS_EOI      = 5'h0D;
    localparam logic [4:0] GPIO_OFS_DBEN     = 5'h0E;
    localparam logic [4:0] GPIO_OFS_DBDIV    = 5'h0F;

    // True when a word offset falls inside the register map.
    function automatic logic gpio_ofs_mapped(input logic [4:0] ofs);
        return (int'(ofs) < GPIO_NUM_REGS);
    endfunction

endpackage

// File: rtl/gpio_in_filt.sv
// Per-bit input path: 2-flop synchroniser, optional debounce filter
// (GPIO_DEBOUNCE_EN), delayed copy s_d and rise/fall pulses of the
// filtered value s.
module gpio_in_filt (
    input  logic pclk,
    input  logic presetn,
`ifdef GPIO_DEBOUNCE_EN
    input  logic tick,
    input  logic db_en,
`endif
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       s_d_reg;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) sync_reg <= '0;
        else          sync_reg <= {sync_reg[0], din};
    end

`ifdef GPIO_DEBOUNCE_EN
    logic samp_reg;
    logic filt_reg;

    // Debounce: on each tick take a sample; accept it when it matches the
    // previous tick's sample. While disabled the filter tracks the sync
    // output so enabling it later causes no spurious edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            samp_reg <= 1'b0;
            filt_reg <= 1'b0;
        end else if (!db_en) begin
            samp_reg <= sync_reg[1];
            filt_reg <= sync_reg[1];
        end else if (tick) begin
            samp_reg <= sync_reg[1];
            if (sync_reg[1] == samp_reg) filt_reg <= sync_reg[1];
        end
    end

    assign s = db_en ? filt_reg : sync_reg[1];
`else
    assign s = sync_reg[1];
`endif

    // Previous filtered value for edge detection.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) s_d_reg <= 1'b0;
        else          s_d_reg <= s;
    end

    assign rise = s & ~s_d_reg;
    assign fall = ~s & s_d_reg;

endmodule

// File: rtl/gpio_apb_n.sv
// N-bit APB GPIO port with set/clear/toggle writes, synchronised inputs and
// per-bit level/edge/both-edge interrupts. Define GPIO_DEBOUNCE_EN to build
// the per-bit debounce filter and its shared prescaler.
module gpio_apb_n
    import gpio_pkg::*;
#(
    parameter int GPIO_W   = 8,
    parameter int DB_CNT_W = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [6:2]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic [GPIO_W-1:0] gpio_intr,
    output logic              gpio_intr_flag
);

    logic [GPIO_W-1:0] dr_reg, ddr_reg, inten_reg, intmask_reg;
    logic [GPIO_W-1:0] inttype_reg, pol_reg, both_reg, edge_reg, edge_next;
    logic [GPIO_W-1:0] s_vec, rise_vec, fall_vec;
    logic [GPIO_W-1:0] edge_hit, eoi_clr, level_raw, rawstat, intstat;
    logic [GPIO_W-1:0] wdata;
    logic              wr_en;
    logic              flag_reg;
    logic [31:0]       rdata;
    logic              unused_wdata;

    assign wr_en        = psel & penable & pwrite;
    assign wdata        = pwdata[GPIO_W-1:0];
    assign unused_wdata = ^pwdata;

`ifdef GPIO_DEBOUNCE_EN
    logic [GPIO_W-1:0]   dben_reg;
    logic [DB_CNT_W-1:0] dbdiv_reg, cnt_reg;
    logic                tick;

    assign tick = (cnt_reg >= dbdiv_reg);

    // Shared prescaler: one tick every DBDIV+1 clocks.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)  cnt_reg <= '0;
        else if (tick) cnt_reg <= '0;
        else           cnt_reg <= cnt_reg + 1'b1;
    end

    // Debounce configuration registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            dben_reg  <= '0;
            dbdiv_reg <= '0;
        end else if (wr_en) begin
            if (paddr == GPIO_OFS_DBEN)  dben_reg  <= wdata;
            if (paddr == GPIO_OFS_DBDIV) dbdiv_reg <= pwdata[DB_CNT_W-1:0];
        end
    end
`else
    localparam int UNUSED_DB_W = DB_CNT_W;
`endif

    // One input filter per bit.
    for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_filt
        gpio_in_filt u_filt (
            .pclk    (pclk),
            .presetn (presetn),
`ifdef GPIO_DEBOUNCE_EN
            .tick    (tick),
            .db_en   (dben_reg[gi]),
`endif
            .din     (gpio_in[gi]),
            .s       (s_vec[gi]),
            .rise    (rise_vec[gi]),
            .fall    (fall_vec[gi])
        );
    end

    // Control register file, including atomic set/clear/toggle of DR.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            dr_reg      <= '0;
            ddr_reg     <= '0;
            inten_reg   <= '0;
            intmask_reg <= '0;
            inttype_reg <= '0;
            pol_reg     <= '0;
            both_reg    <= '0;
        end else if (wr_en) begin
            case (paddr)
                GPIO_OFS_DR:       dr_reg      <= wdata;
                GPIO_OFS_DDR:      ddr_reg     <= wdata;
                GPIO_OFS_SET:      dr_reg      <= dr_reg | wdata;
                GPIO_OFS_CLR:      dr_reg      <= dr_reg & ~wdata;
                GPIO_OFS_TGL:      dr_reg      <= dr_reg ^ wdata;
                GPIO_OFS_INTEN:    inten_reg   <= wdata;
                GPIO_OFS_INTMASK:  intmask_reg <= wdata;
                GPIO_OFS_INTTYPE:  inttype_reg <= wdata;
                GPIO_OFS_POLARITY: pol_reg     <= wdata;
                GPIO_OFS_BOTHEDGE: both_reg    <= wdata;
                default: ;
            endcase
        end
    end

    // Edge bits: a new edge beats a simultaneous EOI; disabling a bit clears it.
    assign edge_hit  = inttype_reg & inten_reg &
                       ((both_reg & (rise_vec | fall_vec)) |
                        (~both_reg & pol_reg & rise_vec) |
                        (~both_reg & ~pol_reg & fall_vec));
    assign eoi_clr   = (wr_en && paddr == GPIO_OFS_EOI) ? wdata : '0;
    assign edge_next = inten_reg & (edge_hit | (edge_reg & ~eoi_clr));
    assign level_raw = inten_reg & ~(s_vec ^ pol_reg);
    assign rawstat   = (inttype_reg & edge_reg) | (~inttype_reg & level_raw);
    assign intstat   = rawstat & ~intmask_reg;

    // Sticky edge status and the registered summary flag.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            edge_reg <= '0;
            flag_reg <= 1'b0;
        end else begin
            edge_reg <= edge_next;
            flag_reg <= |intstat;
        end
    end

    // Combinational read mux; write-only and unmapped offsets read 0.
    always_comb begin
        rdata = '0;
        if (psel && !pwrite) begin
            case (paddr)
                GPIO_OFS_DR:       rdata = 32'(dr_reg);
                GPIO_OFS_DDR:      rdata = 32'(ddr_reg);
                GPIO_OFS_EXT:      rdata = 32'(s_vec);
                GPIO_OFS_INTEN:    rdata = 32'(inten_reg);
                GPIO_OFS_INTMASK:  rdata = 32'(intmask_reg);
                GPIO_OFS_INTTYPE:  rdata = 32'(inttype_reg);
                GPIO_OFS_POLARITY: rdata = 32'(pol_reg);
                GPIO_OFS_BOTHEDGE: rdata = 32'(both_reg);
                GPIO_OFS_RAWSTAT:  rdata = 32'(rawstat);
                GPIO_OFS_INTSTAT:  rdata = 32'(intstat);
`ifdef GPIO_DEBOUNCE_EN
                GPIO_OFS_DBEN:     rdata = 32'(dben_reg);
                GPIO_OFS_DBDIV:    rdata = 32'(dbdiv_reg);
`endif
                default:           rdata = '0;
            endcase
        end
    end

    assign prdata         = rdata;
    assign pready         = 1'b1;
    assign pslverr        = psel & penable & ~gpio_ofs_mapped(paddr);
    assign gpio_out       = dr_reg;
    assign gpio_oe        = ddr_reg;
    assign gpio_intr      = intstat;
    assign gpio_intr_flag = flag_reg;

endmodule

// File: tb/tb_gpio_apb_n.sv
// Directed self-checking bench for gpio_apb_n (8-bit port). The debounce
// steps run only when GPIO_DEBOUNCE_EN is defined for the build.
module tb_gpio_apb_n;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [6:2]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  gpio_in, gpio_out, gpio_oe, gpio_intr;
    logic        gpio_intr_flag;

    int n_pass  = 0;
    int n_total = 0;

    gpio_apb_n #(.GPIO_W(8), .DB_CNT_W(16)) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .prdata         (prdata),
        .pready         (pready),
        .pslverr        (pslverr),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .gpio_oe        (gpio_oe),
        .gpio_intr      (gpio_intr),
        .gpio_intr_flag (gpio_intr_flag)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr[6:2]; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        $display("write addr=%h data=%h", addr, data);
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr[6:2];
        @(negedge pclk);
        penable = 1'b1;
        #1;
        data = prdata;
        err  = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        $display("read  addr=%h data=%h err=%b", addr, data, err);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0;
        wait_clk(3);
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_gpio_intr", 32'(gpio_intr), 32'h0);
        check("rst_flag", 32'(gpio_intr_flag), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        presetn = 1'b1;
        wait_clk(2);

        // 1. all offsets read zero, pready high, unmapped offset errors
        for (int i = 0; i < 16; i++) begin
            apb_read(8'(i * 4), rd, er);
            check($sformatf("rd0_ofs%02h", i * 4), rd, 32'h0);
            check($sformatf("err0_ofs%02h", i * 4), 32'(er), 32'h0);
        end
        check("pready", 32'(pready), 32'h1);
        apb_read(8'h40, rd, er);
        check("rd_unmapped", rd, 32'h0);
        check("err_unmapped", 32'(er), 32'h1);

        // upper bits ignored, then DR set/clear/toggle
        apb_write(8'h00, 32'hFFFF_FFFF);
        apb_read(8'h00, rd, er);
        check("dr_width", rd, 32'h0000_00FF);
        apb_write(8'h00, 32'h0F);
        apb_write(8'h08, 32'h30);
        check("dr_set", 32'(gpio_out), 32'h3F);
        apb_write(8'h0C, 32'h01);
        check("dr_clr", 32'(gpio_out), 32'h3E);
        apb_write(8'h10, 32'h81);
        check("dr_tgl", 32'(gpio_out), 32'hBF);
        apb_read(8'h00, rd, er);
        check("dr_read", rd, 32'hBF);
        apb_read(8'h08, rd, er);
        check("set_reads0", rd, 32'h0);
        apb_write(8'h04, 32'hA5);
        check("ddr_oe", 32'(gpio_oe), 32'hA5);

        // EXT follows the synchronised input
        gpio_in = 8'h5A;
        wait_clk(3);
        apb_read(8'h14, rd, er);
        check("ext_5a", rd, 32'h5A);
        gpio_in = 8'h00;
        wait_clk(4);

`ifndef GPIO_DEBOUNCE_EN
        apb_write(8'h38, 32'hFF);
        apb_read(8'h38, rd, er);
        check("dben_absent", rd, 32'h0);
        check("dben_no_err", 32'(er), 32'h0);
`endif

        // 3. rising-edge interrupt on bit 0, latency and EOI
        apb_write(8'h18, 32'h01);
        apb_write(8'h20, 32'h01);
        apb_write(8'h24, 32'h01);
        gpio_in[0] = 1'b1;
        wait_clk(2);
        check("edge0_lat2", 32'(gpio_intr), 32'h00);
        wait_clk(1);
        check("edge0_lat3", 32'(gpio_intr), 32'h01);
        check("flag_lat3", 32'(gpio_intr_flag), 32'h0);
        wait_clk(1);
        check("flag_lat4", 32'(gpio_intr_flag), 32'h1);
        apb_read(8'h2C, rd, er);
        check("raw_edge0", rd, 32'h01);
        apb_write(8'h34, 32'h01);
        apb_read(8'h2C, rd, er);
        check("raw_after_eoi", rd, 32'h00);
        check("flag_after_eoi", 32'(gpio_intr_flag), 32'h0);

        // 4. both-edge on bit 2, EOI racing an edge
        apb_write(8'h18, 32'h05);
        apb_write(8'h20, 32'h05);
        apb_write(8'h28, 32'h04);
        gpio_in[2] = 1'b1;
        wait_clk(4);
        check("both_rise", 32'(gpio_intr), 32'h04);
        apb_write(8'h34, 32'h04);
        check("both_eoi1", 32'(gpio_intr), 32'h00);
        gpio_in[2] = 1'b0;
        wait_clk(4);
        check("both_fall", 32'(gpio_intr), 32'h04);
        apb_write(8'h34, 32'h04);
        check("both_eoi2", 32'(gpio_intr), 32'h00);
        @(negedge pclk);
        gpio_in[2] = 1'b1;
        apb_write(8'h34, 32'h04);
        check("edge_beats_eoi", 32'(gpio_intr), 32'h04);
        apb_write(8'h34, 32'h04);
        check("eoi_final", 32'(gpio_intr), 32'h00);

        // 5. masked level-low on bit 3, then unmask, then async reset
        gpio_in[3] = 1'b0;
        apb_write(8'h1C, 32'h08);
        apb_write(8'h18, 32'h0D);
        apb_read(8'h2C, rd, er);
        check("level_raw", rd, 32'h08);
        check("level_masked", 32'(gpio_intr), 32'h00);
        apb_read(8'h30, rd, er);
        check("intstat_masked", rd, 32'h00);
        apb_write(8'h1C, 32'h00);
        check("level_unmasked", 32'(gpio_intr), 32'h08);
        wait_clk(1);
        check("level_flag", 32'(gpio_intr_flag), 32'h1);
        #2;
        presetn = 1'b0;
        #1;
        check("arst_intr", 32'(gpio_intr), 32'h00);
        check("arst_flag", 32'(gpio_intr_flag), 32'h0);
        check("arst_out", 32'(gpio_out), 32'h00);
        check("arst_oe", 32'(gpio_oe), 32'h00);
        wait_clk(2);
        gpio_in = 8'h00;
        presetn = 1'b1;
        wait_clk(4);

`ifdef GPIO_DEBOUNCE_EN
        // 6. debounce on bit 0
        apb_write(8'h3C, 32'h3);
        apb_write(8'h38, 32'h01);
        apb_read(8'h3C, rd, er);
        check("dbdiv_read", rd, 32'h3);
        wait_clk(10);
        gpio_in[0] = 1'b1;
        wait_clk(3);
        gpio_in[0] = 1'b0;
        wait_clk(12);
        apb_read(8'h14, rd, er);
        check("db_glitch", rd, 32'h0);
        gpio_in[0] = 1'b1;
        wait_clk(20);
        apb_read(8'h14, rd, er);
        check("db_level", rd, 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
